// File: rtl/heart_sprite_drawer.sv
// Heart sprite overlay stage: maps the scan position to a sprite ROM address, aligns the
// ROM read latency, applies colour-key transparency and the post-hit invulnerability blink.
module heart_sprite_drawer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_on,
  input  logic       frame_start,
  input  logic [9:0] heart_x,
  input  logic [9:0] heart_y,
  input  logic       hurt,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] pix_rgb,
  output logic       pix_valid,
  output logic       invuln
);

  localparam int unsigned SPR_W        = 31;
  localparam int unsigned SPR_H        = 27;
  localparam int unsigned INV_FRAMES   = 60;
  localparam int unsigned BLINK_FRAMES = 4;
  localparam int unsigned CNT_W        = 6;
  localparam logic [7:0]  TRANSP       = 8'hE3;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] INVULN = 1'b1;

  logic [9:0]       pos_x;
  logic [9:0]       pos_y;
  logic             v1;
  logic             v2;
  logic [0:0]       state;
  logic [0:0]       state_n;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_cnt_n;

  logic [10:0]      x_end;
  logic [10:0]      y_end;
  logic             in_box;
  logic [4:0]       col;
  logic [4:0]       row;
  logic [9:0]       addr;
  logic [CNT_W-1:0] blink_idx;
  logic             visible;
  logic             opaque;

  // Hit test; box ends are 11 bits so a sprite near column/row 1023 cannot wrap to 0.
  always_comb begin
    x_end  = 11'(pos_x) + 11'(SPR_W);
    y_end  = 11'(pos_y) + 11'(SPR_H);
    in_box = video_on && (pix_x >= pos_x) && (11'(pix_x) < x_end)
                      && (pix_y >= pos_y) && (11'(pix_y) < y_end);
    col    = 5'(pix_x - pos_x);
    row    = 5'(pix_y - pos_y);
    // row*31 + col as row*32 - row + col
    addr   = 10'({row, 5'b00000}) - 10'(row) + 10'(col);
  end

  always_comb begin
    blink_idx = frame_cnt / CNT_W'(BLINK_FRAMES);
    visible   = (state == IDLE) || !blink_idx[0];
    opaque    = v2 && (rom_data != TRANSP) && visible;
  end

  // Blink FSM next state; a frame_start coinciding with hurt in IDLE is not counted.
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    case (state)
      IDLE: begin
        if (hurt) begin
          state_n     = INVULN;
          frame_cnt_n = '0;
        end
      end
      INVULN: begin
        if (frame_start) begin
          if (frame_cnt == CNT_W'(INV_FRAMES - 1)) begin
            state_n     = IDLE;
            frame_cnt_n = '0;
          end else begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n     = IDLE;
        frame_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      invuln    <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      invuln    <= (state_n == INVULN);
    end
  end

  // Position latch and the three-stage pixel pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x     <= '0;
      pos_y     <= '0;
      rom_addr  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      pix_rgb   <= 8'h00;
      pix_valid <= 1'b0;
    end else begin
      if (frame_start) begin
        pos_x <= heart_x;
        pos_y <= heart_y;
      end
      rom_addr  <= in_box ? addr : 10'd0;
      v1        <= in_box;
      v2        <= v1;
      pix_valid <= opaque;
      pix_rgb   <= opaque ? rom_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_heart_sprite_drawer.sv
// Scoreboard bench for heart_sprite_drawer: directed pixel vectors queue their expected
// ROM address and pixel; a monitor checks them at the fixed pipeline latency.
module tb_heart_sprite_drawer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       frame_start;
  logic [9:0] heart_x;
  logic [9:0] heart_y;
  logic       hurt;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] pix_rgb;
  logic       pix_valid;
  logic       invuln;

  heart_sprite_drawer dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .frame_start(frame_start), .heart_x(heart_x), .heart_y(heart_y), .hurt(hurt),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .invuln(invuln)
  );

  always #5 clk = ~clk;

  // Sprite ROM model: word = low address byte, with a red word at 0 and the key at 31.
  function automatic logic [7:0] rom_f(input logic [9:0] a);
    if (a == 10'd0)  return 8'hE0;
    if (a == 10'd31) return 8'hE3;
    return a[7:0];
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] addr;
    logic       valid;
    logic [7:0] rgb;
  } exp_t;

  exp_t aq[$];
  exp_t pq[$];
  exp_t ea;
  exp_t ep;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: address one cycle after the pixel, colour three cycles after.
  always @(negedge clk) begin
    while (aq.size() > 0 && aq[0].cyc + 1 <= cyc) begin
      ea = aq.pop_front();
      check({ea.name, "/rom_addr"}, int'(rom_addr), int'(ea.addr));
    end
    while (pq.size() > 0 && pq[0].cyc + 3 <= cyc) begin
      ep = pq.pop_front();
      check({ep.name, "/pix_valid"}, int'(pix_valid), int'(ep.valid));
      check({ep.name, "/pix_rgb"}, int'(pix_rgb), int'(ep.rgb));
    end
  end

  task automatic pix(input string name, input int x, input int y, input logic vo,
                     input int eaddr, input logic ev, input logic [7:0] ergb);
    exp_t e;
    @(negedge clk);
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    video_on    = vo;
    frame_start = 1'b0;
    hurt        = 1'b0;
    e.cyc   = cyc;
    e.name  = name;
    e.addr  = 10'(eaddr);
    e.valid = ev;
    e.rgb   = ergb;
    aq.push_back(e);
    pq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      video_on    = 1'b0;
      frame_start = 1'b0;
      hurt        = 1'b0;
    end
  endtask

  task automatic frame(input logic h);
    @(negedge clk);
    video_on    = 1'b0;
    frame_start = 1'b1;
    hurt        = h;
    @(negedge clk);
    frame_start = 1'b0;
    hurt        = 1'b0;
  endtask

  task automatic hurt_pulse();
    @(negedge clk);
    video_on = 1'b0;
    hurt     = 1'b1;
    @(negedge clk);
    hurt     = 1'b0;
  endtask

  initial begin
    logic vis;
    rst_n = 1'b0; pix_x = '0; pix_y = '0; video_on = 1'b0; frame_start = 1'b0;
    hurt = 1'b0; heart_x = 10'd100; heart_y = 10'd200;
    repeat (3) @(negedge clk);
    check("reset/rom_addr", int'(rom_addr), 0);
    check("reset/pix_valid", int'(pix_valid), 0);
    check("reset/pix_rgb", int'(pix_rgb), 0);
    check("reset/invuln", int'(invuln), 0);
    rst_n = 1'b1;

    // Heart at (100,200): corners, outside edges, colour key, blanking
    frame(1'b0);
    pix("tl_corner",  100, 200, 1'b1,   0, 1'b1, 8'hE0);
    pix("br_corner",  130, 226, 1'b1, 836, 1'b1, 8'h44);
    pix("right_out",  131, 200, 1'b1,   0, 1'b0, 8'h00);
    pix("below_out",  100, 227, 1'b1,   0, 1'b0, 8'h00);
    pix("left_out",    99, 200, 1'b1,   0, 1'b0, 8'h00);
    pix("transp_key", 100, 201, 1'b1,  31, 1'b0, 8'h00);
    pix("video_off",  115, 210, 1'b0,   0, 1'b0, 8'h00);
    pix("inner",      105, 203, 1'b1,  98, 1'b1, 8'h62);
    idle(4);

    // Position change only takes effect after frame_start
    heart_x = 10'd300;
    pix("old_pos_held", 100, 200, 1'b1, 0, 1'b1, 8'hE0);
    pix("new_pos_early", 300, 200, 1'b1, 0, 1'b0, 8'h00);
    idle(2);
    frame(1'b0);
    pix("old_pos_gone", 100, 200, 1'b1,   0, 1'b0, 8'h00);
    pix("new_pos_tl",   300, 200, 1'b1,   0, 1'b1, 8'hE0);
    pix("new_pos_br",   330, 226, 1'b1, 836, 1'b1, 8'h44);
    idle(4);

    // Right-edge sprite must not wrap to column 0
    heart_x = 10'd1010;
    frame(1'b0);
    pix("edge_first", 1010, 200, 1'b1,   0, 1'b1, 8'hE0);
    pix("edge_last",  1023, 200, 1'b1,  13, 1'b1, 8'h0D);
    pix("edge_br",    1023, 226, 1'b1, 819, 1'b1, 8'h33);
    pix("no_wrap",       0, 200, 1'b1,   0, 1'b0, 8'h00);
    idle(4);

    // Invulnerability blink over 60 frames, second hurt ignored
    heart_x = 10'd100;
    frame(1'b0);
    hurt_pulse();
    check("invuln_set", int'(invuln), 1);
    pix("blink_f0", 100, 200, 1'b1, 0, 1'b1, 8'hE0);
    idle(3);
    for (int f = 1; f <= 60; f++) begin
      frame(1'b0);
      if (f == 10) hurt_pulse();
      check($sformatf("invuln_f%0d", f), int'(invuln), (f < 60) ? 1 : 0);
      vis = (f >= 60) || (((f / 4) % 2) == 0);
      pix($sformatf("blink_f%0d", f), 100, 200, 1'b1, 0, vis, vis ? 8'hE0 : 8'h00);
      idle(3);
    end

    // Reset mid-invulnerability
    hurt_pulse();
    for (int f = 1; f <= 20; f++) frame(1'b0);
    check("invuln_f20", int'(invuln), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_invuln", int'(invuln), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    rst_n = 1'b1;

    // hurt and frame_start together: that frame_start is not counted
    frame(1'b1);
    check("hurt_fs_invuln", int'(invuln), 1);
    pix("hurt_fs_f0", 100, 200, 1'b1, 0, 1'b1, 8'hE0);
    idle(3);
    repeat (3) frame(1'b0);
    pix("hurt_fs_f3", 100, 200, 1'b1, 0, 1'b1, 8'hE0);
    idle(3);
    frame(1'b0);
    pix("hurt_fs_f4", 100, 200, 1'b1, 0, 1'b0, 8'h00);
    idle(6);

    if (aq.size() != 0 || pq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d address and %0d pixel expectations left unchecked",
               aq.size(), pq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/heart_sprite_drawer.md
# heart_sprite_drawer

Pixel-pipeline stage that drives the heart sprite ROM and consumes its colour output to produce the player heart's overlay pixel for the VGA mixer. It maps the scan position and the heart's position to a ROM address, aligns the 1-cycle ROM read latency, applies colour-key transparency, and runs the post-hit invulnerability blink. The heart position is latched once per frame so the sprite never tears. It sits between the VGA timing generator / soul movement logic upstream and the colour mixer downstream.

## Interface

- SPR_W, 31: sprite width in pixels.
- SPR_H, 27: sprite height in pixels; SPR_W*SPR_H = 837 ROM words.
- TRANSP, 8'hE3: RGB332 colour key treated as transparent.
- INV_FRAMES, 60: invulnerability duration in frames.
- BLINK_FRAMES, 4: frames per blink half-period.

- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- pix_x  in  10  current scan column.
- pix_y  in  10  current scan row.
- video_on  in  1  active-area flag for pix_x/pix_y.
- frame_start  in  1  1-cycle pulse at start of vertical blank.
- heart_x  in  10  sprite top-left column from movement logic.
- heart_y  in  10  sprite top-left row.
- hurt  in  1  1-cycle damage pulse.
- rom_addr  out  10  address to the sprite ROM (ROM registers data on the next edge).
- rom_data  in  8  ROM output word.
- pix_rgb  out  8  overlay colour; 8'h00 when pix_valid is low.
- pix_valid  out  1  heart pixel is opaque and visible this cycle.
- invuln  out  1  high while invulnerable.

## Operation

- Position latch: pos_x/pos_y load heart_x/heart_y on every cycle with frame_start high; otherwise hold.
- Hit test (stage 0, combinational): in_box = video_on && pix_x >= pos_x && pix_x < pos_x+SPR_W && pix_y >= pos_y && pix_y < pos_y+SPR_H; sums computed 11 bits wide so a sprite near column/row 1023 does not wrap.
- Address: col = pix_x - pos_x, row = pix_y - pos_y; addr = row*SPR_W + col (range 0..836), computed as shift/subtract, no multiplier required. rom_addr registered; loads 0 when !in_box.
- Stage 1 registers in_box as v1; stage 2 registers v1 as v2 in step with ROM data.
- Output (stage 3 register): pix_valid = v2 && rom_data != TRANSP && visible; pix_rgb = rom_data when that term is true, else 8'h00.
- Blink FSM, states IDLE and INVULN:
  - IDLE: visible = 1, invuln = 0. hurt -> INVULN, frame_cnt = 0.
  - INVULN: invuln = 1. Each frame_start increments frame_cnt; visible = ((frame_cnt / BLINK_FRAMES) is even). When frame_cnt reaches INV_FRAMES-1 and frame_start occurs -> IDLE.
  - hurt in INVULN is ignored; the timer is not restarted.
  - hurt and frame_start in the same IDLE cycle: enter INVULN with frame_cnt = 0, and that frame_start is not counted.
- Reset: state IDLE, frame_cnt 0, pos_x/pos_y 0, rom_addr 0, v1/v2 0, pix_rgb 8'h00, pix_valid 0, invuln 0. Reset mid-frame or mid-INVULN returns to these values at the next edge. pix_valid is not asserted until three cycles after rst_n rises.

## Timing

- Pixel presented in cycle N: rom_addr valid in N+1; rom_data valid in N+2; pix_rgb/pix_valid valid in N+3. Fixed 3-cycle latency, so upstream must delay hsync/vsync/blank by 3 cycles.
- Throughput: one pixel per clock, no stalls.
- A heart_x/heart_y change takes effect on the first pixel after the next frame_start.
- invuln and visible change only on the edge after hurt or frame_start. visible is applied at stage 3, so a blink boundary may shift by up to 3 pixels, which is acceptable inside blanking.

## Test plan

- Heart at (100,200); scan pixel (100,200) with video_on -> rom_addr = 0 at N+1; with rom_data = 8'hE0, pix_valid = 1 and pix_rgb = 8'hE0 at N+3.
- Pixel (130,226) -> rom_addr = 836. Pixels (131,200) and (100,227) -> pix_valid = 0 and pix_rgb = 8'h00.
- rom_data = 8'hE3 inside the box -> pix_valid = 0. video_on low inside the box -> pix_valid = 0.
- heart_x changed mid-frame from 100 to 300 -> pixel (100,200) is still drawn until frame_start, after which it is drawn at (300,200).
- heart_x = 1010 -> pixels 1010..1023 are drawn and pix_x = 0 is not (no wrap).
- Pulse hurt -> invuln = 1. Frames 0-3 visible, 4-7 hidden. A second hurt at frame 10 does not extend the timer. invuln falls after the 60th frame_start. rst_n low at frame 20 clears invuln on the next edge.
